// File: rtl/alu_unit.sv
// alu_unit: registered 8-op integer ALU with N/Z/C/V flags and a valid bit travelling alongside the result
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             out_valid
);
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } alu_opcode_t;
  localparam int M = WIDTH - 1;
  alu_opcode_t op;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] res, out_d, out_q;
  logic [3:0] flags_d, flags_q;
  logic c, v, out_valid_d, out_valid_q;
  assign op = alu_opcode_t'(alu_op);
  assign sum = {1'b0, in1} + {1'b0, in2};
  // the extra top bit of an unsigned subtract is the borrow
  assign diff = {1'b0, in1} - {1'b0, in2};
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[M:0];
        c = sum[WIDTH];
        v = (in1[M] == in2[M]) && (sum[M] != in1[M]);
      end
      OP_SUB: begin
        res = diff[M:0];
        c = diff[WIDTH];
        v = (in1[M] != in2[M]) && (diff[M] != in1[M]);
      end
      OP_AND: res = in1 & in2;
      OP_OR:  res = in1 | in2;
      OP_XOR: res = in1 ^ in2;
      OP_SLL: begin
        res = {in1[M-1:0], 1'b0};
        c = in1[M];
      end
      OP_SRL: begin
        res = {1'b0, in1[M:1]};
        c = in1[0];
      end
      OP_SRA: begin
        res = {in1[M], in1[M:1]};
        c = in1[0];
      end
      default: res = '0;
    endcase
    out_d = in_valid ? res : out_q;
    flags_d = in_valid ? {res[M], res == '0, c, v} : flags_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      flags_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      flags_q <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out = out_q;
  assign flags = flags_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed test-plan vectors plus randomized ops checked against an arithmetic reference model
module tb_alu_unit;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [7:0] in1 = '0, in2 = '0, out;
  logic [2:0] alu_op = '0;
  logic [3:0] flags;
  logic out_valid;
  int checks = 0, errors = 0;
  logic [7:0] m_out = '0;
  logic [3:0] m_flags = '0;

  alu_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in1(in1), .in2(in2),
    .alu_op(alu_op), .out(out), .flags(flags), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    alu_op = op;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ev, input logic [7:0] eo, input logic [3:0] ef);
    checks++;
    assert ({out_valid, out, flags} === {ev, eo, ef})
    else begin
      errors++;
      $error("FAIL %s: got valid=%b out=%h nzcv=%b, expected valid=%b out=%h nzcv=%b",
             tag, out_valid, out, flags, ev, eo, ef);
    end
  endtask

  // Reference: plain integer arithmetic with signed-range tests for overflow
  task automatic model(input int op, input int a, input int b, output logic [7:0] ro, output logic [3:0] rf);
    int r, sa, sb, sr, cy, ov;
    sa = a >= 128 ? a - 256 : a;
    sb = b >= 128 ? b - 256 : b;
    cy = 0;
    ov = 0;
    case (op)
      0: begin r = (a + b) % 256; cy = (a + b) >= 256; sr = sa + sb; ov = sr > 127 || sr < -128; end
      1: begin r = (a - b + 256) % 256; cy = a < b; sr = sa - sb; ov = sr > 127 || sr < -128; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 256; cy = a >= 128; end
      6: begin r = a / 2; cy = a % 2; end
      default: begin r = a / 2 + (a >= 128 ? 128 : 0); cy = a % 2; end
    endcase
    ro = r[7:0];
    rf = {r >= 128, r == 0, cy != 0, ov != 0};
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("reset", 1'b0, 8'h00, 4'b0000);
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h12, 8'h34);
    chk("idle", 1'b0, 8'h00, 4'b0000);

    drive(1'b1, 3'd0, 8'h01, 8'h01); chk("add_01_01", 1'b1, 8'h02, 4'b0000);
    drive(1'b1, 3'd0, 8'hFF, 8'h01); chk("add_ff_01", 1'b1, 8'h00, 4'b0110);
    drive(1'b1, 3'd0, 8'h7F, 8'h01); chk("add_7f_01", 1'b1, 8'h80, 4'b1001);
    drive(1'b1, 3'd0, 8'h80, 8'h80); chk("add_80_80", 1'b1, 8'h00, 4'b0111);
    drive(1'b0, 3'd0, 8'h05, 8'h05); chk("hold", 1'b0, 8'h00, 4'b0111);

    drive(1'b1, 3'd1, 8'h05, 8'h03); chk("sub_05_03", 1'b1, 8'h02, 4'b0000);
    drive(1'b1, 3'd1, 8'h00, 8'h01); chk("sub_00_01", 1'b1, 8'hFF, 4'b1010);
    drive(1'b1, 3'd1, 8'h80, 8'h01); chk("sub_80_01", 1'b1, 8'h7F, 4'b0001);
    drive(1'b1, 3'd1, 8'h01, 8'h01); chk("sub_01_01", 1'b1, 8'h00, 4'b0100);

    drive(1'b1, 3'd2, 8'hF0, 8'h0F); chk("and", 1'b1, 8'h00, 4'b0100);
    drive(1'b1, 3'd3, 8'hF0, 8'h0F); chk("or", 1'b1, 8'hFF, 4'b1000);
    drive(1'b1, 3'd4, 8'hAA, 8'h55); chk("xor", 1'b1, 8'hFF, 4'b1000);

    drive(1'b1, 3'd5, 8'h01, 8'h00); chk("sll_01", 1'b1, 8'h02, 4'b0000);
    drive(1'b1, 3'd5, 8'h80, 8'h00); chk("sll_80", 1'b1, 8'h00, 4'b0110);
    drive(1'b1, 3'd6, 8'h02, 8'h00); chk("srl_02", 1'b1, 8'h01, 4'b0000);
    drive(1'b1, 3'd7, 8'h80, 8'h00); chk("sra_80", 1'b1, 8'hC0, 4'b1000);
    drive(1'b1, 3'd7, 8'h81, 8'h00); chk("sra_81", 1'b1, 8'hC0, 4'b1010);

    rst = 1'b1;
    drive(1'b1, 3'd0, 8'h7F, 8'h01); chk("mid_reset", 1'b0, 8'h00, 4'b0000);
    rst = 1'b0;
    drive(1'b1, 3'd0, 8'h7F, 8'h01); chk("after_reset", 1'b1, 8'h80, 4'b1001);
    m_out = 8'h80;
    m_flags = 4'b1001;

    for (int i = 0; i < 300; i++) begin
      logic v;
      logic [2:0] op;
      logic [7:0] a, b, ro;
      logic [3:0] rf;
      v = $urandom_range(0, 9) < 8;
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 7 == 0) a = 8'h80;
      if (i % 11 == 0) b = 8'hFF;
      model(int'(op), int'(a), int'(b), ro, rf);
      if (v) begin
        m_out = ro;
        m_flags = rf;
      end
      drive(v, op, a, b);
      chk($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), v, m_out, m_flags);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
